// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch front end: 2-flop synchronizers, per-button debounce, and single-cycle start/stop/reset commands.
// Define LONG_PRESS_RESET_EN to add a long-hold reset on the start/stop button.
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16,
  parameter int HOLD_CYCLES     = 50000,
  parameter int HOLD_W          = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       btn_ss_db,
  output logic       btn_rst_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-only sanity hook; the block stays empty for legal settings.
  if ((DEBOUNCE_CYCLES < 2) || (HOLD_CYCLES < 1) || (HOLD_W < 1)) begin : g_cfg_out_of_range
  end

  // Index 0 = start/stop button, index 1 = reset button.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       dly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             press_ss_s, press_rst_s, rst_evt_s;
  logic             start_q, stop_q, reset_q;
  logic             start_d, stop_d, reset_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {btn_rst_raw, btn_ss_raw};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = {CNT_W{1'b0}};
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 2'b00;
      dly_q    <= 2'b00;
      cnt_q[0] <= {CNT_W{1'b0}};
      cnt_q[1] <= {CNT_W{1'b0}};
    end else begin
      stable_q <= stable_d;
      dly_q    <= stable_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign press_ss_s  = stable_q[0] & ~dly_q[0];
  assign press_rst_s = stable_q[1] & ~dly_q[1];

`ifdef LONG_PRESS_RESET_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_evt_s;

  // One reset per hold: the event fires on the step into HOLD_CYCLES, then the counter saturates.
  assign long_evt_s = stable_q[0] & (hold_q == HOLD_W'(HOLD_CYCLES - 1));

  always_comb begin
    hold_d = hold_q;
    if (!stable_q[0]) begin
      hold_d = {HOLD_W{1'b0}};
    end else if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= {HOLD_W{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end

  assign rst_evt_s = press_rst_s | long_evt_s;
`else
  assign rst_evt_s = press_rst_s;
`endif

  // Reset has priority; a start/stop press with an invalid status is dropped.
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    reset_d = 1'b0;
    if (rst_evt_s) begin
      reset_d = 1'b1;
    end else if (press_ss_s) begin
      case (status)
        2'b00, 2'b10: start_d = 1'b1;
        2'b01:        stop_d  = 1'b1;
        default:      start_d = 1'b0;
      endcase
    end else begin
      reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      reset_q <= reset_d;
    end
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign reset      = reset_q;
  assign btn_ss_db  = stable_q[0];
  assign btn_rst_db = stable_q[1];

endmodule

// File: doc/stopwatch_button_ctrl.md
Name: stopwatch_button_ctrl

Overview:
Front-end command generator for the stopwatch control FSM. It takes two raw, asynchronous, bouncing push-buttons (start/stop toggle and reset) and synchronizes and debounces each one. It then emits single-cycle start, stop and reset command pulses. The start/stop mapping uses the FSM status fed back to this block. It sits between the board pins and the FSM's start/stop/reset inputs.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive stable clock cycles required before a button level change is accepted (min 2).
CNT_W, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
HOLD_CYCLES, 50000, long-press threshold in clock cycles; used only with the optional feature.
HOLD_W, 17, width of the hold counter; must hold HOLD_CYCLES.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_ss_raw  input  1  raw start/stop button, active-high, asynchronous
btn_rst_raw  input  1  raw reset button, active-high, asynchronous
status  input  2  FSM status: 00=IDLE, 01=RUNNING, 10=PAUSED, 11 invalid
start  output  1  one-cycle start/resume command pulse
stop  output  1  one-cycle stop/pause command pulse
reset  output  1  one-cycle functional reset command pulse
btn_ss_db  output  1  debounced start/stop level
btn_rst_db  output  1  debounced reset level

Behaviour:
- Reset (rst_n low, async):
  - All synchronizer flops, stable levels, delayed levels, counters and command outputs go to 0.
  - start, stop, reset, btn_ss_db and btn_rst_db are all 0.
- Synchronizer: each raw input passes through a 2-flop synchronizer. No logic is placed between the two flops.
- Debounce, per button; stable level drives btn_*_db:
  - If the synced level equals the stable level, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and the synced level still differs, the stable level takes the synced value and the counter clears.
  - Any return of the synced level to the stable level before the threshold clears the counter. A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- Press detect: press = stable high AND delayed-stable low, where delayed-stable is a one-cycle registered copy. Release generates no event.
- Latency: a clean raw rise produces its command pulse high for exactly one cycle, after rising edge number DEBOUNCE_CYCLES+3 following the raw edge.
- Command mapping (registered; status is sampled in the same cycle as the press):
  - rst press: reset=1, independent of status.
  - ss press with status 00 or 10: start=1.
  - ss press with status 01: stop=1.
  - ss press with status 11: no pulse; the press is discarded.
- Simultaneous events:
  - rst press and ss press in the same cycle: only reset=1; the ss press is dropped.
  - At most one of start/stop/reset is high in any cycle.
- Held button: exactly one pulse per press. No auto-repeat while held.
- Reset mid-operation: all debounce progress is lost. A button held through rst_n deassertion is treated as a new press and yields a command pulse after the full latency.
- No internal FSM beyond the per-button debounce state. Outputs are registered, so there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LONG_PRESS_RESET_EN.
- Defined:
  - A hold counter counts cycles while btn_ss_db is high. It clears when btn_ss_db is low.
  - When the counter reaches HOLD_CYCLES, reset pulses for one cycle. The counter saturates, so only one reset is issued per hold.
  - The start/stop pulse issued at press time is unaffected.
  - If the long-press reset coincides with a btn_rst press, a single reset pulse is issued.
- Not defined:
  - No hold counter is built, and HOLD_CYCLES/HOLD_W are unused.
  - reset comes only from btn_rst_raw.

Test Plan:
- rst_n low 3 cycles with both buttons high -> start=stop=reset=0 and btn_ss_db=btn_rst_db=0 throughout reset.
- DEBOUNCE_CYCLES=4, status=00, btn_ss_raw rises and holds 20 cycles -> start=1 only after edge 7, low after edge 8; btn_ss_db=1 from edge 6; no stop or reset.
- DEBOUNCE_CYCLES=4, status=00, btn_ss_raw toggles every 2 cycles for 12 cycles then stays high -> exactly one start pulse, after the final settle plus latency 7.
- status=01, clean ss press -> exactly one stop pulse, no start. status=11, clean ss press -> no pulse.
- btn_ss_raw and btn_rst_raw rise on the same edge, status=10 -> one reset pulse after edge 7, no start.
- LONG_PRESS_RESET_EN, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, status=00, ss held 40 cycles -> start pulse after edge 7, single reset pulse 16 cycles after btn_ss_db rises. Without the macro -> start only, no reset.
